sdram_traffic_gen: RTL and testbench
====================================

SDRAM_TRAFFIC_GEN -- requirements
Module: sdram_traffic_gen

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, 32, request address width; DATA_WIDTH, 32, data width; GAP_CYCLES, 20, idle cycles after each completed op; TIMEOUT_CYCLES, 1024, max wait for wvalid/rvalid.
REQ-002 Ports SHALL be: clk input 1 sole clock; rst input 1 synchronous active-high reset.
REQ-003 Ports SHALL be: start input 1, one-cycle pulse that begins a run; num_ops input 16, write/read pairs per run; seed input 32, LFSR seed sampled at start.
REQ-004 Ports SHALL be: busy output 1, run in progress; done output 1, one-cycle pulse at run end; pass_count output 16, matching reads; err_count output 16, mismatches plus timeouts.
REQ-005 Port ctrl_if SHALL be sdram_ctrl_if.man (ADDR_WIDTH, DATA_WIDTH), driving addr, write_data, wr, rd and sampling rdy, wvalid, rvalid, read_data; it attaches to one sdram_arb subordinate port.

Function
REQ-006 FSM states SHALL be IDLE, WR_REQ, WR_WAIT, GAP_W, RD_REQ, RD_WAIT, CHECK, GAP_R.
REQ-007 IDLE with start=1 SHALL load LFSR (seed 0 replaced by 1), clear counters and op index, set busy, go WR_REQ; num_ops=0 SHALL instead pulse done next cycle and stay IDLE.
REQ-008 WR_REQ SHALL drive addr=LFSR, write_data=next LFSR step, wr=1 until a cycle with wr&rdy; wr SHALL be 0 and write_data 0 the following cycle; state then WR_WAIT.
REQ-009 WR_WAIT SHALL leave on wvalid=1 to GAP_W; GAP_W SHALL hold GAP_CYCLES cycles then go RD_REQ.
REQ-010 RD_REQ SHALL drive the same addr with rd=1 until rd&rdy; rd SHALL be 0 the following cycle; state RD_WAIT.
REQ-011 RD_WAIT SHALL capture read_data in the rvalid=1 cycle and go CHECK; CHECK (one cycle) SHALL increment pass_count if equal to the written word, else err_count.
REQ-012 GAP_R SHALL hold GAP_CYCLES cycles, advance LFSR two steps, increment op index; when index reaches num_ops it SHALL pulse done, clear busy, go IDLE, else WR_REQ.
REQ-013 wr and rd SHALL never both be 1; addr and write_data SHALL be stable while a request is held.
REQ-014 LFSR SHALL be 32-bit Galois, polynomial 0x80200003, one step per use; addr = LFSR[ADDR_WIDTH-1:0].
REQ-015 Counters SHALL saturate at 0xFFFF; start while busy SHALL be ignored.
REQ-016 rvalid/wvalid arriving in any state other than the matching wait state SHALL be ignored.

Reset
REQ-017 On a clk edge with rst=1: state IDLE; wr, rd, busy, done 0; addr, write_data, counters, op index 0; LFSR 1.
REQ-018 rst mid-request SHALL drop wr/rd at that edge; no partial count update SHALL occur.

Configuration
REQ-019 Macro SDRAM_TGEN_TIMEOUT_EN defined: WR_WAIT/RD_WAIT SHALL count cycles from acceptance; reaching TIMEOUT_CYCLES increments err_count and proceeds to GAP_W/GAP_R (read not compared).
REQ-020 Macro undefined: no timeout counter SHALL exist; wait states wait indefinitely.

Verification
REQ-021 Through sdram_arb + sdram_core + MT48LC8M16A2, seed=1, num_ops=10 -> done pulse, pass_count=10, err_count=0.
REQ-022 Two instances on portA/portB, seeds 0x1234/0xBEEF, num_ops=8 each -> both pass_count=8, wr/rd never overlap within an instance.
REQ-023 Stub subordinate with rdy low 5 cycles -> wr held 6 cycles, addr/data stable, deasserted cycle after acceptance.
REQ-024 Stub returning read_data XOR 1 -> err_count=num_ops, pass_count=0.
REQ-025 With SDRAM_TGEN_TIMEOUT_EN, stub never asserts rvalid, num_ops=2, TIMEOUT_CYCLES=16 -> err_count=2, done pulses.
REQ-026 rst asserted during RD_WAIT -> next cycle all outputs at reset values; new start completes normally.

Source files
------------

// File: rtl/sdram_traffic_gen_if.sv
// sdram_ctrl_if: manager/subordinate request bus for SDRAM arbiter ports.
// man drives addr/write_data/wr/rd; sub returns rdy/wvalid/rvalid/read_data.
interface sdram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  wr;
  logic                  rd;
  logic                  rdy;
  logic                  wvalid;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] read_data;

  modport man (
    output addr, write_data, wr, rd,
    input  rdy, wvalid, rvalid, read_data
  );

  modport sub (
    input  addr, write_data, wr, rd,
    output rdy, wvalid, rvalid, read_data
  );
endinterface

// File: rtl/sdram_traffic_gen.sv
// sdram_traffic_gen: LFSR write/read-back traffic generator for one SDRAM port.
// Ports: clk, rst (sync, high), start/num_ops/seed in; busy/done/pass_count/
// err_count out; ctrl_if (sdram_ctrl_if.man) to the arbiter.
// Optional: define SDRAM_TGEN_TIMEOUT_EN to bound WR_WAIT/RD_WAIT.
module sdram_traffic_gen #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int GAP_CYCLES     = 20,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_ops,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic [15:0] pass_count,
  output logic [15:0] err_count,
  sdram_ctrl_if.man   ctrl_if
);

  localparam logic [31:0] POLY = 32'h8020_0003;
  localparam logic [31:0] GAP_LAST =
    (GAP_CYCLES > 1) ? 32'(GAP_CYCLES - 1) : 32'd0;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_WAIT, GAP_W,
    RD_REQ, RD_WAIT, CHECK, GAP_R
  } state_t;

  state_t state_q, state_d;

  logic [31:0]           lfsr_q, lfsr_d;
  logic [31:0]           lfsr_nx, lfsr_nx2;
  logic [15:0]           pass_q, pass_d;
  logic [15:0]           err_q, err_d;
  logic [15:0]           idx_q, idx_d;
  logic [15:0]           nops_q, nops_d;
  logic [31:0]           gap_q, gap_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] exp_data;
  logic                  gap_end;
  logic                  last_op;
  logic                  tmo_hit;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] v
  );
    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Written word is always one LFSR step past the address.
  assign lfsr_nx  = lfsr_step(lfsr_q);
  assign lfsr_nx2 = lfsr_step(lfsr_nx);
  assign exp_data = DATA_WIDTH'(lfsr_nx);
  assign gap_end  = (gap_q >= GAP_LAST);
  assign last_op  = ((idx_q + 16'd1) == nops_q);

`ifdef SDRAM_TGEN_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST =
    (TIMEOUT_CYCLES > 1) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [31:0] tmo_q, tmo_d;
  logic        in_wait;

  assign in_wait = (state_q == WR_WAIT) ||
                   (state_q == RD_WAIT);
  assign tmo_hit = in_wait && (tmo_q >= TMO_LAST);
  assign tmo_d   = in_wait ? tmo_q + 32'd1 : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) tmo_q <= 32'd0;
    else     tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start && (num_ops != 16'd0))
          state_d = WR_REQ;
      WR_REQ:
        if (ctrl_if.rdy) state_d = WR_WAIT;
      WR_WAIT:
        if (ctrl_if.wvalid || tmo_hit)
          state_d = GAP_W;
      GAP_W:
        if (gap_end) state_d = RD_REQ;
      RD_REQ:
        if (ctrl_if.rdy) state_d = RD_WAIT;
      RD_WAIT:
        if (ctrl_if.rvalid)  state_d = CHECK;
        else if (tmo_hit)    state_d = GAP_R;
      CHECK:
        state_d = GAP_R;
      GAP_R:
        if (gap_end)
          state_d = last_op ? IDLE : WR_REQ;
      default:
        state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    lfsr_d  = lfsr_q;
    pass_d  = pass_q;
    err_d   = err_q;
    idx_d   = idx_q;
    nops_d  = nops_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    gap_d   = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_ops == 16'd0) begin
            done_d = 1'b1;
          end else begin
            lfsr_d = (seed == 32'd0) ? 32'd1 : seed;
            pass_d = 16'd0;
            err_d  = 16'd0;
            idx_d  = 16'd0;
            nops_d = num_ops;
          end
        end
      end
      WR_WAIT: begin
        if (!ctrl_if.wvalid && tmo_hit)
          err_d = sat_inc(err_q);
      end
      GAP_W: begin
        gap_d = gap_end ? 32'd0 : gap_q + 32'd1;
      end
      RD_WAIT: begin
        if (ctrl_if.rvalid)
          rdata_d = ctrl_if.read_data;
        else if (tmo_hit)
          err_d = sat_inc(err_q);
      end
      CHECK: begin
        if (rdata_q == exp_data)
          pass_d = sat_inc(pass_q);
        else
          err_d = sat_inc(err_q);
      end
      GAP_R: begin
        gap_d = gap_end ? 32'd0 : gap_q + 32'd1;
        if (gap_end) begin
          lfsr_d = lfsr_nx2;
          idx_d  = idx_q + 16'd1;
          done_d = last_op;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q  <= 32'd1;
      pass_q  <= 16'd0;
      err_q   <= 16'd0;
      idx_q   <= 16'd0;
      nops_q  <= 16'd0;
      gap_q   <= 32'd0;
      rdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      nops_q  <= nops_d;
      gap_q   <= gap_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
    end
  end

  // Outputs: request lines decode straight from state, so they
  // drop in the cycle after acceptance and on reset.
  always_comb begin
    ctrl_if.wr         = 1'b0;
    ctrl_if.rd         = 1'b0;
    ctrl_if.addr       = '0;
    ctrl_if.write_data = '0;
    unique case (state_q)
      WR_REQ: begin
        ctrl_if.wr         = 1'b1;
        ctrl_if.addr       = ADDR_WIDTH'(lfsr_q);
        ctrl_if.write_data = exp_data;
      end
      RD_REQ: begin
        ctrl_if.rd   = 1'b1;
        ctrl_if.addr = ADDR_WIDTH'(lfsr_q);
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign pass_count = pass_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_sdram_traffic_gen.sv
// tb_sdram_traffic_gen: randomized bench with a behavioural stub subordinate
// and an LFSR sequence model for sdram_traffic_gen.
module tb_sdram_traffic_gen;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_ops;
  logic [31:0] seed;
  logic        busy;
  logic        done;
  logic [15:0] pass_count;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;

  sdram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_traffic_gen #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .num_ops(num_ops), .seed(seed),
    .busy(busy), .done(done),
    .pass_count(pass_count), .err_count(err_count),
    .ctrl_if(bus.man)
  );

  always #5 clk = ~clk;

  // stub configuration
  int stall_fixed = -1;
  int lat_fixed   = -1;
  bit corrupt     = 1'b0;
  bit spurious    = 1'b0;
  bit drop_rvalid = 1'b0;

  // observations
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [31:0] ra_q[$];
  int len_q[$];
  int gap_q[$];
  int overlap_err, stable_err, post_err, done_cnt;

  // stub state
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit wpend, rpend;
  int wcnt, rcnt, reqcnt, cur_stall, cyc, wv_cyc;
  logic [AW-1:0] raddr, p_addr;
  logic [DW-1:0] p_data;
  logic p_wr, p_rd, p_rdy;

  function automatic logic [31:0] step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int pick_lat();
    return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(3, 0));
  endfunction

  // Subordinate stub + bus monitor, evaluated mid-cycle.
  initial begin
    bus.rdy = 1'b0; bus.wvalid = 1'b0;
    bus.rvalid = 1'b0; bus.read_data = '0;
    wpend = 0; rpend = 0; reqcnt = 0; cyc = 0;
    wv_cyc = 0; cur_stall = 0;
    p_wr = 0; p_rd = 0; p_rdy = 0; p_addr = '0; p_data = '0;
    overlap_err = 0; stable_err = 0; post_err = 0; done_cnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (bus.wr && bus.rd) overlap_err++;
      bus.wvalid = 1'b0;
      bus.rvalid = 1'b0;
      if (rst) begin
        wpend = 0; rpend = 0; bus.rdy = 1'b0;
        p_wr = 0; p_rd = 0; p_rdy = 0;
      end else begin
        if (p_rdy && p_wr) begin
          mem[p_addr] = p_data;
          wa_q.push_back(p_addr);
          wd_q.push_back(p_data);
          len_q.push_back(reqcnt);
          wpend = 1; wcnt = pick_lat();
          if (bus.wr || bus.write_data != '0) post_err++;
        end
        if (p_rdy && p_rd) begin
          ra_q.push_back(p_addr);
          len_q.push_back(reqcnt);
          rpend = !drop_rvalid; raddr = p_addr; rcnt = pick_lat();
          if (bus.rd) post_err++;
        end
        if (wpend) begin
          if (wcnt == 0) begin
            bus.wvalid = 1'b1; wpend = 0; wv_cyc = cyc;
          end else wcnt--;
        end
        if (rpend) begin
          if (rcnt == 0) begin
            bus.rvalid = 1'b1; rpend = 0;
            bus.read_data = (mem.exists(raddr) ? mem[raddr] : '0)
                            ^ DW'(corrupt);
          end else rcnt--;
        end
        if (bus.wr || bus.rd) begin
          if (((bus.wr && p_wr) || (bus.rd && p_rd)) && !p_rdy) begin
            reqcnt++;
            if (bus.addr !== p_addr ||
                (bus.wr && bus.write_data !== p_data))
              stable_err++;
          end else begin
            reqcnt = 1;
            cur_stall = (stall_fixed >= 0) ? stall_fixed
                        : int'($urandom_range(3, 0));
            if (bus.rd) gap_q.push_back(cyc - wv_cyc);
          end
          bus.rdy = (reqcnt > cur_stall);
          if (spurious && !bus.rdy && $urandom_range(1, 0) == 1) begin
            bus.wvalid = 1'b1;
            bus.rvalid = 1'b1;
            bus.read_data = $urandom;
          end
        end else begin
          bus.rdy = 1'b0;
        end
        p_wr = bus.wr; p_rd = bus.rd; p_rdy = bus.rdy;
        p_addr = bus.addr; p_data = bus.write_data;
      end
    end
  end

  task automatic clear_obs();
    wa_q.delete(); wd_q.delete(); ra_q.delete();
    len_q.delete(); gap_q.delete();
    overlap_err = 0; stable_err = 0; post_err = 0; done_cnt = 0;
  endtask

  // Launch a run and wait (bounded) for done; poke >= 0 issues a
  // second start with a different seed that must be ignored.
  task automatic do_run(input logic [31:0] s, input logic [15:0] n,
                        input int poke, output bit ok);
    clear_obs();
    seed = s; num_ops = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400 * int'(n) + 100; i++) begin
      if (done) begin ok = 1'b1; break; end
      if (i == poke) begin
        seed = ~s; num_ops = n + 16'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; seed = '0; num_ops = '0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++;
      $display("FAIL reset_busy got %0b exp 0", busy); end
    tests++; if (done !== 1'b0) begin fails++;
      $display("FAIL reset_done got %0b exp 0", done); end
    tests++; if ({bus.wr, bus.rd} !== 2'b00) begin fails++;
      $display("FAIL reset_wr_rd got %b exp 00", {bus.wr, bus.rd}); end
    tests++; if (bus.addr !== '0 || bus.write_data !== '0) begin fails++;
      $display("FAIL reset_addr_data got %h/%h exp 0",
               bus.addr, bus.write_data); end
    tests++; if (pass_count !== 16'd0 || err_count !== 16'd0) begin
      fails++; $display("FAIL reset_counts got %0d/%0d exp 0/0",
                        pass_count, err_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_seq(input string nm, input logic [31:0] s,
                           input int n);
    logic [31:0] l;
    int bad;
    l = (s == 32'd0) ? 32'd1 : s;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (k >= wa_q.size() || k >= ra_q.size()) bad++;
      else if (wa_q[k] !== l || wd_q[k] !== step(l) ||
               ra_q[k] !== l) bad++;
      l = step(step(l));
    end
    tests++; if (bad != 0 || wa_q.size() != n) begin fails++;
      $display("FAIL %s_seq got %0d bad ops (%0d writes) exp 0 bad (%0d)",
               nm, bad, wa_q.size(), n); end
  endtask

  task automatic test_random_runs();
    logic [31:0] s;
    logic [15:0] n;
    bit ok;
    int badgap;
    for (int r = 0; r < 3; r++) begin
      s = $urandom; n = 16'($urandom_range(6, 2));
      stall_fixed = -1; lat_fixed = -1;
      spurious = 1'b1; corrupt = 1'b0;
      do_run(s, n, -1, ok);
      tests++; if (!ok) begin fails++;
        $display("FAIL rand_done_timeout run %0d", r); end
      tests++; if (pass_count !== n || err_count !== 16'd0) begin
        fails++; $display("FAIL rand_counts got %0d/%0d exp %0d/0",
                          pass_count, err_count, n); end
      tests++; if (done_cnt != 1 || busy !== 1'b0) begin fails++;
        $display("FAIL rand_done_pulse got %0d pulses busy %0b exp 1/0",
                 done_cnt, busy); end
      check_seq("rand", s, int'(n));
      tests++; if (overlap_err + stable_err + post_err != 0) begin
        fails++; $display("FAIL rand_protocol got %0d/%0d/%0d exp 0/0/0",
                          overlap_err, stable_err, post_err); end
      badgap = 0;
      foreach (gap_q[i]) if (gap_q[i] != GAP + 1) badgap++;
      tests++; if (badgap != 0) begin fails++;
        $display("FAIL rand_gap got %0d bad gaps exp 0", badgap); end
    end
    spurious = 1'b0;
  endtask

  task automatic test_rdy_stall();
    bit ok;
    stall_fixed = 5; lat_fixed = 1;
    do_run(32'hCAFE_0001, 16'd1, -1, ok);
    tests++; if (!ok || len_q.size() != 2) begin fails++;
      $display("FAIL stall_run got ok %0b %0d reqs exp 1/2",
               ok, len_q.size()); end
    else begin
      tests++; if (len_q[0] != 6 || len_q[1] != 6) begin fails++;
        $display("FAIL stall_hold got %0d/%0d exp 6/6",
                 len_q[0], len_q[1]); end
    end
    tests++; if (stable_err != 0 || post_err != 0) begin fails++;
      $display("FAIL stall_stable got %0d/%0d exp 0/0",
               stable_err, post_err); end
    tests++; if (gap_q.size() != 1 || gap_q[0] != GAP + 1) begin
      fails++; $display("FAIL stall_gap got %0d exp %0d",
                        (gap_q.size() > 0) ? gap_q[0] : -1, GAP + 1); end
    stall_fixed = -1; lat_fixed = -1;
  endtask

  task automatic test_corrupt();
    bit ok;
    corrupt = 1'b1;
    do_run($urandom, 16'd3, -1, ok);
    tests++; if (!ok || err_count !== 16'd3 || pass_count !== 16'd0)
    begin fails++;
      $display("FAIL corrupt got ok %0b err %0d pass %0d exp 1/3/0",
               ok, err_count, pass_count); end
    corrupt = 1'b0;
  endtask

  task automatic test_zero_ops();
    clear_obs();
    seed = 32'h55; num_ops = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL zero_ops got done %0b busy %0b exp 1/0",
               done, busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0 || bus.wr !== 1'b0)
    begin fails++;
      $display("FAIL zero_ops_after got done %0b busy %0b wr %0b exp 0",
               done, busy, bus.wr); end
  endtask

  task automatic test_seed_zero();
    bit ok;
    do_run(32'd0, 16'd1, -1, ok);
    tests++; if (!ok || wa_q.size() != 1) begin fails++;
      $display("FAIL seed0_run got ok %0b writes %0d exp 1/1",
               ok, wa_q.size()); end
    else begin
      tests++; if (wa_q[0] !== 32'd1 || wd_q[0] !== step(32'd1)) begin
        fails++; $display("FAIL seed0_addr got %h/%h exp 1/%h",
                          wa_q[0], wd_q[0], step(32'd1)); end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    logic [31:0] s;
    s = $urandom;
    do_run(s, 16'd2, 12, ok);
    tests++; if (!ok || pass_count !== 16'd2 || done_cnt != 1) begin
      fails++; $display("FAIL busy_start got ok %0b pass %0d done %0d exp 1/2/1",
                        ok, pass_count, done_cnt); end
    check_seq("busy_start", s, 2);
  endtask

  task automatic test_rst_mid();
    bit ok;
    int i;
    clear_obs();
    lat_fixed = 12; stall_fixed = 0;
    seed = $urandom; num_ops = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (i = 0; i < 200 && ra_q.size() == 0; i++) @(negedge clk);
    tests++; if (ra_q.size() == 0) begin fails++;
      $display("FAIL rst_mid_no_read got 0 reads exp 1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++; if ({busy, done, bus.wr, bus.rd} !== 4'b0 ||
                 bus.addr !== '0 || pass_count !== 16'd0 ||
                 err_count !== 16'd0) begin fails++;
      $display("FAIL rst_mid got busy %0b done %0b addr %h cnt %0d/%0d exp 0",
               busy, done, bus.addr, pass_count, err_count); end
    rst = 1'b0;
    lat_fixed = -1; stall_fixed = -1;
    @(negedge clk);
    do_run($urandom, 16'd2, -1, ok);
    tests++; if (!ok || pass_count !== 16'd2 || err_count !== 16'd0)
    begin fails++;
      $display("FAIL rst_mid_rerun got ok %0b %0d/%0d exp 1/2/0",
               ok, pass_count, err_count); end
  endtask

`ifdef SDRAM_TGEN_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    drop_rvalid = 1'b1;
    do_run($urandom, 16'd2, -1, ok);
    tests++; if (!ok || err_count !== 16'd2 || pass_count !== 16'd0)
    begin fails++;
      $display("FAIL timeout got ok %0b err %0d pass %0d exp 1/2/0",
               ok, err_count, pass_count); end
    drop_rvalid = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0; num_ops = '0;
    test_reset();
    test_zero_ops();
    test_seed_zero();
    test_rdy_stall();
    test_random_runs();
    test_corrupt();
    test_start_while_busy();
    test_rst_mid();
`ifdef SDRAM_TGEN_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
